// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the byte-wide RAM port and mem_arbiter.
// The arbiter uses the slave modport; the requester/RAM side uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch and load/store.
// Each transaction becomes N little-endian byte accesses; MEM wins ties in IDLE.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [23:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    logic [ADDR_W-1:0] next_a_s;
    logic [31:0]       cap_s;
    logic [7:0]        wbyte_s;
    logic [2:0]        mem_n_s;
    logic              grant_mem_s, grant_if_s, rd_last_s, wr_last_s, more_s;

    // A requester whose done pulse is showing still holds a stale request, so it is masked.
    assign grant_mem_s = bus.mem_req && !mem_done_q;
    assign grant_if_s  = !grant_mem_s && bus.if_req && !bus.if_flush && !if_done_q;
    // cyc_q counts cycles since the grant: address cyc_q+1 goes out next, lane cyc_q-1 is captured now.
    assign rd_last_s   = (cyc_q == n_q);
    assign wr_last_s   = ((cyc_q + 3'd1) == n_q);
    assign more_s      = ((cyc_q + 3'd1) < n_q);
    assign next_a_s    = base_q + {{(ADDR_W-3){1'b0}}, cyc_q + 3'd1};

    assign bus.stallreq_if  = bus.if_req & ~if_done_q;
    assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;
    assign bus.if_data      = if_data_q;
    assign bus.if_done      = if_done_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.mem_done     = mem_done_q;
    assign bus.ram_dout     = ram_dout_q;
    assign bus.ram_a        = ram_a_q;
    assign bus.ram_wr       = ram_wr_q;

    // Decode byte count, next store byte and the read buffer with this cycle's byte merged.
    always_comb begin
        case (bus.mem_size)
            2'd0:    mem_n_s = 3'd1;
            2'd1:    mem_n_s = 3'd2;
            default: mem_n_s = 3'd4;
        endcase
        case (cyc_q)
            3'd0:    wbyte_s = wdata_q[7:0];
            3'd1:    wbyte_s = wdata_q[15:8];
            3'd2:    wbyte_s = wdata_q[23:16];
            default: wbyte_s = 8'h00;
        endcase
        cap_s = buf_q;
        case (cyc_q)
            3'd1:    cap_s[7:0]   = bus.ram_din;
            3'd2:    cap_s[15:8]  = bus.ram_din;
            3'd3:    cap_s[23:16] = bus.ram_din;
            3'd4:    cap_s[31:24] = bus.ram_din;
            default: cap_s = buf_q;
        endcase
    end

    // State register: synchronous reset, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end else begin
            state_q <= state_q;
        end
    end

    // Next-state logic; a flush abandons a fetch even on its final capture edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_mem_s) begin
                    state_d = bus.mem_we ? MEM_WR : MEM_RD;
                end else if (grant_if_s) begin
                    state_d = IF_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_RD: begin
                if (bus.if_flush || rd_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = IF_RD;
                end
            end
            MEM_RD: begin
                if (rd_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_WR: begin
                if (wr_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = MEM_WR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of counters, latched request and registered outputs.
    always_comb begin
        cyc_d       = cyc_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_mem_s) begin
                    base_d   = bus.mem_addr;
                    n_d      = mem_n_s;
                    wdata_d  = bus.mem_wdata[31:8];
                    cyc_d    = 3'd0;
                    buf_d    = 32'h0000_0000;
                    ram_a_d  = bus.mem_addr;
                    ram_wr_d = bus.mem_we;
                    if (bus.mem_we) begin
                        ram_dout_d = bus.mem_wdata[7:0];
                    end else begin
                        ram_dout_d = ram_dout_q;
                    end
                end else if (grant_if_s) begin
                    base_d  = bus.if_addr;
                    n_d     = 3'd4;
                    cyc_d   = 3'd0;
                    buf_d   = 32'h0000_0000;
                    ram_a_d = bus.if_addr;
                end else begin
                    cyc_d = cyc_q;
                end
            end
            IF_RD, MEM_RD: begin
                if ((state_q == IF_RD) && bus.if_flush) begin
                    cyc_d = cyc_q;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                    buf_d = cap_s;
                    if (more_s) begin
                        ram_a_d = next_a_s;
                    end else begin
                        ram_a_d = ram_a_q;
                    end
                    if (rd_last_s && (state_q == IF_RD)) begin
                        if_data_d = cap_s;
                        if_done_d = 1'b1;
                    end else if (rd_last_s) begin
                        mem_rdata_d = cap_s;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_done_d = 1'b0;
                    end
                end
            end
            MEM_WR: begin
                if (wr_last_s) begin
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                end else begin
                    ram_wr_d   = 1'b1;
                    ram_a_d    = next_a_s;
                    ram_dout_d = wbyte_s;
                    cyc_d      = cyc_q + 3'd1;
                end
            end
            default: begin
                cyc_d = 3'd0;
            end
        endcase
    end

    // Datapath and output registers, all held while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= 3'd0;
            n_q         <= 3'd0;
            base_q      <= {ADDR_W{1'b0}};
            wdata_q     <= 24'h00_0000;
            buf_q       <= 32'h0000_0000;
            ram_a_q     <= {ADDR_W{1'b0}};
            ram_dout_q  <= 8'h00;
            ram_wr_q    <= 1'b0;
            if_data_q   <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else if (rdy) begin
            cyc_q       <= cyc_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end else begin
            cyc_q       <= cyc_q;
            n_q         <= n_q;
            base_q      <= base_q;
            wdata_q     <= wdata_q;
            buf_q       <= buf_q;
            ram_a_q     <= ram_a_q;
            ram_dout_q  <= ram_dout_q;
            ram_wr_q    <= ram_wr_q;
            if_data_q   <= if_data_q;
            mem_rdata_q <= mem_rdata_q;
            if_done_q   <= if_done_q;
            mem_done_q  <= mem_done_q;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random transactions
// compared against a byte-array memory model and cycle-count rules.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bit [7:0] ram   [bit [31:0]];
    bit [7:0] model [bit [31:0]];

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic bit [7:0] model_rd(input bit [31:0] a);
        return model.exists(a) ? model[a] : 8'h00;
    endfunction

    // Synchronous RAM, one-cycle read latency; its output register is frozen by rdy like the core.
    always @(posedge clk) begin
        if (rdy) bus.ram_din <= ram_rd(bus.ram_a);
        if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit [31:0] a, input bit [7:0] v);
        ram[a]   = v;
        model[a] = v;
    endtask

    function automatic logic [31:0] exp_read(input bit [31:0] a, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = model_rd(a + 32'(k));
        return r;
    endfunction

    // Cycle index after a freeze of fl edges starting with the edge that ends cycle ff.
    function automatic int sh(input int u, input int ff, input int fl);
        return (fl > 0 && u >= ff) ? u + fl : u;
    endfunction

    // One transaction from IDLE; call 1 time unit after a rising edge (that cycle is cycle 0).
    task automatic do_txn(input bit isif, input bit we, input logic [1:0] sz, input bit [31:0] a,
                          input logic [31:0] wd, input int ff, input int fl, output logic [31:0] got);
        int          n, eu, ed, dc;
        logic [31:0] exp_d;
        logic [31:0] la [64];
        logic        lw [64];
        logic [7:0]  ld [64];
        logic        odone;
        n     = isif ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        eu    = (isif || !we) ? n + 2 : n + 1;
        ed    = sh(eu, ff, fl);
        exp_d = exp_read(a, n);
        got   = 32'h0;
        dc    = -1;
        odone = 1'b0;
        if (isif) begin
            bus.if_addr = a;
            bus.if_req  = 1'b1;
        end else begin
            bus.mem_we    = we;
            bus.mem_size  = sz;
            bus.mem_addr  = a;
            bus.mem_wdata = wd;
            bus.mem_req   = 1'b1;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            la[c] = bus.ram_a;
            lw[c] = bus.ram_wr;
            ld[c] = bus.ram_dout;
            if (isif ? bus.if_done : bus.mem_done) begin
                dc    = c;
                got   = isif ? bus.if_data : bus.mem_rdata;
                odone = isif ? bus.mem_done : bus.if_done;
                chk("stall_at_done", {31'h0, isif ? bus.stallreq_if : bus.stallreq_mem}, 32'h0);
                bus.if_req  = 1'b0;
                bus.mem_req = 1'b0;
                break;
            end
            chk("stall_busy", {31'h0, isif ? bus.stallreq_if : bus.stallreq_mem}, (c < ed) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            if (fl > 0 && c + 1 == ff) rdy = 1'b0;
            if (fl > 0 && c + 1 == ff + fl) rdy = 1'b1;
        end
        rdy         = 1'b1;
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        @(posedge clk);
        #1;
        chk("done_cycle", dc, ed);
        chk("other_done", {31'h0, odone}, 32'h0);
        if (isif || !we) begin
            chk("rd_data", got, exp_d);
            chk("rd_no_wr", {31'h0, lw[sh(1, ff, fl)]}, 32'h0);
            for (int k = 0; k < n; k++) chk("rd_addr", la[sh(1 + k, ff, fl)], a + 32'(k));
        end else begin
            for (int k = 0; k < n; k++) begin
                chk("wr_strobe", {31'h0, lw[sh(1 + k, ff, fl)]}, 32'h1);
                chk("wr_addr", la[sh(1 + k, ff, fl)], a + 32'(k));
                chk("wr_byte", {24'h0, ld[sh(1 + k, ff, fl)]}, {24'h0, wd[8*k +: 8]});
                model[a + 32'(k)] = wd[8*k +: 8];
            end
            chk("wr_end", {31'h0, lw[ed]}, 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got, last_if, a4, mdat, idat, a;
        int          md, id, n, eu, ff, fl;
        bit          isif, we;
        logic [1:0]  sz;

        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ram_a", bus.ram_a, 32'h0);
        chk("rst_ram_dout", {24'h0, bus.ram_dout}, 32'h0);
        chk("rst_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_if_done", {31'h0, bus.if_done}, 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst_mem_done", {31'h0, bus.mem_done}, 32'h0);
        chk("rst_stall_if", {31'h0, bus.stallreq_if}, 32'h0);
        @(posedge clk);
        #1;

        // Word fetch.
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        do_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 0, 0, got);
        chk("fetch_word", got, 32'h4433_2211);

        // Half store then byte load.
        do_txn(1'b0, 1'b1, 2'd1, 32'h200, 32'hAABB_CCDD, 0, 0, got);
        chk("half_store_b0", {24'h0, ram_rd(32'h200)}, 32'hDD);
        chk("half_store_b1", {24'h0, ram_rd(32'h201)}, 32'hCC);
        chk("half_store_b2", {24'h0, ram_rd(32'h202)}, 32'h00);
        do_txn(1'b0, 1'b0, 2'd0, 32'h201, 32'h0, 0, 0, got);
        chk("byte_load", got, 32'h0000_00CC);

        // Simultaneous requests: MEM first, IF granted at the edge ending MEM's done cycle.
        bus.mem_we   = 1'b0;
        bus.mem_size = 2'd0;
        bus.mem_addr = 32'h201;
        bus.mem_req  = 1'b1;
        bus.if_addr  = 32'h100;
        bus.if_req   = 1'b1;
        md = -1; id = -1; a4 = 32'h0; mdat = 32'h0; idat = 32'h0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 4) a4 = bus.ram_a;
            if (bus.mem_done && md < 0) begin
                md = c; mdat = bus.mem_rdata; bus.mem_req = 1'b0;
            end
            if (bus.if_done && id < 0) begin
                id = c; idat = bus.if_data; bus.if_req = 1'b0;
            end
            if (id >= 0) break;
            @(posedge clk);
            #1;
        end
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        @(posedge clk);
        #1;
        chk("sim_mem_done_cycle", md, 32'd3);
        chk("sim_if_done_cycle", id, 32'd9);
        chk("sim_if_first_addr", a4, 32'h100);
        chk("sim_mem_data", mdat, exp_read(32'h201, 1));
        chk("sim_if_data", idat, exp_read(32'h100, 4));
        last_if = exp_read(32'h100, 4);

        // Flush in cycle 3 of a fetch, then a fresh fetch elsewhere.
        preload(32'h500, 8'h5A); preload(32'h501, 8'h6B);
        preload(32'h502, 8'h7C); preload(32'h503, 8'h8D);
        preload(32'h600, 8'h01); preload(32'h601, 8'h02);
        preload(32'h602, 8'h03); preload(32'h603, 8'h04);
        bus.if_addr = 32'h500;
        bus.if_req  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.if_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.if_flush = 1'b0;
        bus.if_req   = 1'b0;
        for (int c = 4; c < 10; c++) begin
            @(negedge clk);
            chk("flush_no_done", {31'h0, bus.if_done}, 32'h0);
            chk("flush_if_data", bus.if_data, last_if);
            @(posedge clk);
            #1;
        end
        do_txn(1'b1, 1'b0, 2'd0, 32'h600, 32'h0, 0, 0, got);
        chk("post_flush_fetch", got, 32'h0403_0201);

        // rdy low for three edges in the middle of a word fetch.
        do_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 3, 3, got);
        chk("frozen_fetch", got, 32'h4433_2211);

        // Reset sampled at the edge that opens cycle 2 of a word store.
        preload(32'h400, 8'hA0); preload(32'h401, 8'hA1);
        preload(32'h402, 8'hA2); preload(32'h403, 8'hA3);
        bus.mem_we    = 1'b1;
        bus.mem_size  = 2'd2;
        bus.mem_addr  = 32'h400;
        bus.mem_wdata = 32'h1122_3344;
        bus.mem_req   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk("mrst_ram_a", bus.ram_a, 32'h0);
        chk("mrst_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
        chk("mrst_ram_dout", {24'h0, bus.ram_dout}, 32'h0);
        chk("mrst_if_data", bus.if_data, 32'h0);
        chk("mrst_mem_rdata", bus.mem_rdata, 32'h0);
        for (int c = 0; c < 6; c++) begin
            chk("mrst_no_done", {31'h0, bus.mem_done}, 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk("mrst_b0", {24'h0, ram_rd(32'h400)}, 32'h44);
        chk("mrst_b1", {24'h0, ram_rd(32'h401)}, 32'hA1);
        chk("mrst_b2", {24'h0, ram_rd(32'h402)}, 32'hA2);
        chk("mrst_b3", {24'h0, ram_rd(32'h403)}, 32'hA3);
        model[32'h400] = 8'h44;

        // Address wrap-around.
        preload(32'hFFFF_FFFE, 8'hC1); preload(32'hFFFF_FFFF, 8'hC2);
        preload(32'h0000_0000, 8'hC3); preload(32'h0000_0001, 8'hC4);
        do_txn(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 0, got);
        chk("wrap_word", got, 32'hC4C3_C2C1);

        // Random mix of fetches, loads and stores, some with rdy freezes.
        for (int t = 0; t < 40; t++) begin
            isif = ($urandom_range(0, 3) == 0);
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h300 + 32'($urandom_range(0, 15));
            n  = isif ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            eu = (isif || !we) ? n + 2 : n + 1;
            fl = int'($urandom_range(0, 2));
            ff = (fl > 0) ? int'($urandom_range(1, eu - 1)) : 0;
            do_txn(isif, we, sz, a, $urandom, ff, fl, got);
        end

        foreach (model[k]) chk("ram_final", {24'h0, ram_rd(k)}, {24'h0, model[k]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
